// File: rtl/sift_pixel_rx_pkg.sv
// Shared constants and types for the SIFT pixel receiver front end.
package sift_pixel_rx_pkg;

  // Default frame geometry and datapath widths.
  localparam int unsigned COLS       = 640;
  localparam int unsigned ROWS       = 480;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned COL_W      = $clog2(COLS);
  localparam int unsigned ROW_W      = $clog2(ROWS);

  // Position outputs are fixed-width regardless of the configured geometry.
  localparam int unsigned COL_PORT_W = 10;
  localparam int unsigned ROW_PORT_W = 9;

  // Which half of the held word is currently presented downstream.
  typedef enum logic {
    SelHigh = 1'b0,
    SelLow  = 1'b1
  } byte_sel_e;

endpackage

// File: rtl/sift_pixel_rx_fifo.sv
// Registered synchronous word FIFO with full/empty flags.
// A push while full is accepted only when a pop happens in the same cycle.
module sift_pixel_rx_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             push_ok, pop_ok;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    empty_o = (wptr_q == rptr_q);
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop_ok  = pop_i & ~empty_o;
    push_ok = push_i & (~full_o | pop_ok);
    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop_ok ? rptr_q + 1'b1 : rptr_q;
    data_o  = mem_q[rptr_q[AW-1:0]];
  end

  // Pointer state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/sift_pixel_rx.sv
// SIFT input receiver: buffers 16-bit words, unpacks two pixels per word and
// tags each pixel with its column/row and frame markers. No input backpressure,
// so words arriving while the buffer is full are dropped and flagged.
module sift_pixel_rx
  import sift_pixel_rx_pkg::*;
#(
  parameter int unsigned COLS       = sift_pixel_rx_pkg::COLS,
  parameter int unsigned ROWS       = sift_pixel_rx_pkg::ROWS,
  parameter int unsigned PIX_W      = sift_pixel_rx_pkg::PIX_W,
  parameter int unsigned FIFO_DEPTH = sift_pixel_rx_pkg::FIFO_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  input  logic [2*PIX_W-1:0]    in_data_i,
  input  logic                  pix_ready_i,
  output logic                  pix_valid_o,
  output logic [PIX_W-1:0]      pix_data_o,
  output logic [COL_PORT_W-1:0] pix_col_o,
  output logic [ROW_PORT_W-1:0] pix_row_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  eof_o,
  output logic                  frame_done_o,
  output logic                  overflow_o
);

  localparam int unsigned WordW = 2 * PIX_W;

  logic [WordW-1:0]      fifo_head;
  logic                  fifo_full, fifo_empty;
  logic                  fifo_pop;

  logic [WordW-1:0]      word_q, word_d;
  logic                  wvalid_q, wvalid_d;
  byte_sel_e             sel_q, sel_d;
  logic [COL_PORT_W-1:0] col_q, col_d;
  logic [ROW_PORT_W-1:0] row_q, row_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overflow_q, overflow_d;

  logic                  xfer, low_xfer, col_last, row_last;

  sift_pixel_rx_fifo #(
    .WIDTH (WordW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (in_valid_i),
    .data_i  (in_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Handshake decode, word-register refill and position/flag next state.
  always_comb begin
    xfer     = wvalid_q & pix_ready_i;
    low_xfer = xfer & (sel_q == SelLow);
    col_last = (col_q == COL_PORT_W'(COLS - 1));
    row_last = (row_q == ROW_PORT_W'(ROWS - 1));
    // Refill as the low pixel leaves so the stream has no bubble between words.
    fifo_pop = ~fifo_empty & (~wvalid_q | low_xfer);

    word_d   = word_q;
    wvalid_d = wvalid_q;
    sel_d    = sel_q;
    if (fifo_pop) begin
      word_d   = fifo_head;
      wvalid_d = 1'b1;
      sel_d    = SelHigh;
    end else if (low_xfer) begin
      wvalid_d = 1'b0;
      sel_d    = SelHigh;
    end else if (xfer) begin
      sel_d    = SelLow;
    end

    col_d = col_q;
    row_d = row_q;
    if (xfer) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    frame_done_d = xfer & col_last & row_last;
    overflow_d   = overflow_q | (in_valid_i & fifo_full & ~fifo_pop);
  end

  // All receiver state, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q       <= '0;
      wvalid_q     <= 1'b0;
      sel_q        <= SelHigh;
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      word_q       <= word_d;
      wvalid_q     <= wvalid_d;
      sel_q        <= sel_d;
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Outputs derive from registers only.
  always_comb begin
    pix_valid_o  = wvalid_q;
    pix_data_o   = (sel_q == SelLow) ? word_q[PIX_W-1:0] : word_q[WordW-1:PIX_W];
    pix_col_o    = col_q;
    pix_row_o    = row_q;
    sof_o        = wvalid_q & (col_q == '0) & (row_q == '0);
    eol_o        = wvalid_q & col_last;
    eof_o        = wvalid_q & col_last & row_last;
    frame_done_o = frame_done_q;
    overflow_o   = overflow_q;
  end

endmodule
